delay_seq_sa: RTL and testbench
===============================

# delay_seq_sa

Per-channel sample store and delay-and-sum sequencer for the synthetic-aperture beamforming path. It captures one sample per channel per acquisition cycle into circular line buffers and holds a per-channel delay table. For each requested focal point it reads each channel's sample at `point + delay[ch]` and presents the samples serially to the downstream accumulator, together with the `start_sum` / `sum_en` / `done_channel` framing the accumulator expects.

## Interface

- `DATA_WIDTH`, 16: sample width, unsigned.
- `NUM_CHANNELS`, 4: channel count, N ≥ 2.
- `DEPTH`, 64: samples per channel buffer, power of two.
- `DELAY_WIDTH`, `$clog2(DEPTH)`: width of delay and point index.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: write one sample vector at the write pointer.
- `in_samples` in `DATA_WIDTH*NUM_CHANNELS`: channel c occupies bits `[c*DATA_WIDTH +: DATA_WIDTH]`.
- `delay_we` in 1: delay table write strobe.
- `delay_ch` in `$clog2(NUM_CHANNELS)`: delay table index.
- `delay_val` in `DELAY_WIDTH`: delay value.
- `req_valid` in 1: focal-point request.
- `req_point` in `DELAY_WIDTH`: base sample index.
- `req_ready` out 1: high only in IDLE.
- `start_sum` out 1: one-cycle accumulator clear.
- `sum_en` out 1: `delayed_sample` is valid this cycle.
- `delayed_sample` out `DATA_WIDTH`: current channel sample.
- `done_channel` out 1: one-cycle pulse after the last `sum_en`.

## Operation

**Write side** (independent of the FSM)
- Each `in_valid` cycle writes all channels at `wr_ptr`.
- `wr_ptr` increments modulo `DEPTH` and wraps from `DEPTH-1` to 0.

**Delay table**
- `delay_we` writes `delay[delay_ch]` only when the FSM is in IDLE.
- A `delay_we` asserted in any other state is dropped.

**Read address**
- Address for channel ch is `(req_point + delay[ch]) mod DEPTH`.
- The request point is latched on accept.
- Memory is synchronous read with one-cycle latency and read-first behaviour: a same-cycle write to the same address returns the old data.

**FSM (Moore)**
- IDLE: `req_ready=1`. `req_valid && req_ready` latches the point and moves to START.
- START: `start_sum=1`; issues the read for channel 0. Moves to RUN with ch=0.
- RUN: `sum_en=1`, `delayed_sample` = data for channel ch; issues the read for ch+1. Moves to DONE after ch = N-1.
- DONE: `done_channel=1`. Moves to IDLE.

**Framing rules**
- `start_sum` and `sum_en` never overlap.
- `delayed_sample` is 0 whenever `sum_en=0`.

**Reset**
- Reset at any time, including mid-RUN, returns the FSM to IDLE.
- Reset clears `wr_ptr` and all delays to 0.
- Reset does not clear buffer contents.
- Output reset values: `req_ready=1`; `start_sum`, `sum_en` and `done_channel` = 0; `delayed_sample=0`.
- No partial frame is completed after reset.

## Timing

Request accepted at the rising edge ending cycle T:
- T+1: `start_sum`.
- T+2 … T+1+N: `sum_en`, carrying channels 0 … N-1 in order.
- T+2+N: `done_channel`.
- T+3+N: IDLE with `req_ready=1`. The earliest next accept is at the end of T+3+N.

General rules:
- Throughput is one focal point per N+3 cycles.
- `req_valid` held high while busy is not accepted and is not queued.
- A write during an in-flight frame to an address not yet read is visible to that frame.

## Configuration

Macro `DELAY_SEQ_SA_ZERO_PAD_EN`:
- Defined: if `req_point + delay[ch] ≥ DEPTH` (computed at `DELAY_WIDTH+1` bits), that channel's `delayed_sample` is 0. `sum_en` is still asserted for that channel.
- Undefined: the address wraps modulo `DEPTH`.

## Test plan

Common setup: N=4, DEPTH=64; preload address a with channel c value `c*256+a`.

1. Delays {0,1,2,3}, point 10 -> `start_sum` at T+1. `delayed_sample` = 10, 267, 524, 781 on T+2..T+5. `done_channel` at T+6. Downstream sum = 1582.
2. Delays {0,1,2,3}, point 62, macro undefined -> samples 62, 319, 512, 769. With the macro defined -> 62, 319, 0, 0.
3. `req_valid` held high for two requests -> first accepted at T, second at T+7. `req_ready` low for T+1..T+6.
4. `delay_we` for ch 2 with value 5 asserted during RUN -> ignored. The next frame at point 10 still gives ch 2 = 524.
5. `reset` asserted in the second RUN cycle -> next cycle all outputs at reset values, `req_ready=1`, no `done_channel`. A following request at point 0 with delays {0,0,0,0} returns 0, 256, 512, 768.
6. Write with `wr_ptr` = 63 followed by a write -> the second write lands at address 0. A same-cycle write/read of one address returns the old value.

Source files
------------

// File: rtl/delay_seq_sa.sv
// delay_seq_sa: per-channel circular sample store plus delay-and-sum read
// sequencer. Each in_valid cycle stores one sample per channel at the write
// pointer; each accepted focal-point request reads channel ch at
// (point + delay[ch]) and streams the samples to the downstream accumulator
// framed by start_sum / sum_en / done_channel.
//
// Optional build macro: DELAY_SEQ_SA_ZERO_PAD_EN
//   defined   -> reads whose point + delay reaches past DEPTH-1 yield 0
//   undefined -> the read address wraps modulo DEPTH
module delay_seq_sa #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 4,
    parameter int DEPTH        = 64,
    parameter int DELAY_WIDTH  = $clog2(DEPTH)
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               in_valid_i,
    input  logic [DATA_WIDTH*NUM_CHANNELS-1:0] in_samples_i,
    input  logic                               delay_we_i,
    input  logic [$clog2(NUM_CHANNELS)-1:0]    delay_ch_i,
    input  logic [DELAY_WIDTH-1:0]             delay_val_i,
    input  logic                               req_valid_i,
    input  logic [DELAY_WIDTH-1:0]             req_point_i,
    output logic                               req_ready_o,
    output logic                               start_sum_o,
    output logic                               sum_en_o,
    output logic [DATA_WIDTH-1:0]              delayed_sample_o,
    output logic                               done_channel_o
);

    localparam int CH_W = $clog2(NUM_CHANNELS);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [DELAY_WIDTH-1:0] point_q, point_d;
    logic [DELAY_WIDTH-1:0] wr_ptr_q;
    logic [DELAY_WIDTH-1:0] delay_q [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]  mem_q [NUM_CHANNELS][DEPTH];
    logic [DATA_WIDTH-1:0]  rd_data_q;

    logic [CH_W-1:0]        rd_ch_s;
    logic [DELAY_WIDTH-1:0] rd_delay_s;
    logic [DELAY_WIDTH-1:0] rd_addr_s;
    logic                   sample_ok_s;

    // Next-state logic of the request sequencer
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        point_d = point_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    state_d = ST_START;
                    point_d = req_point_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                state_d = ST_RUN;
                ch_d    = {CH_W{1'b0}};
            end
            ST_RUN: begin
                if (ch_q == LAST_CH) begin
                    state_d = ST_DONE;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state registers; reset abandons any frame in flight
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            ch_q    <= {CH_W{1'b0}};
            point_q <= {DELAY_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            point_q <= point_d;
        end
    end

    // Write pointer advances on every stored vector and wraps at DEPTH
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= {DELAY_WIDTH{1'b0}};
        end else if (in_valid_i) begin
            wr_ptr_q <= wr_ptr_q + DELAY_WIDTH'(1);
        end
    end

    // Delay table: updates are only honoured while no frame is running
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                delay_q[c] <= {DELAY_WIDTH{1'b0}};
            end
        end else if (delay_we_i && (state_q == ST_IDLE) && (int'(delay_ch_i) < NUM_CHANNELS)) begin
            delay_q[delay_ch_i] <= delay_val_i;
        end
    end

    // Channel whose sample is fetched this cycle: ch 0 from START, ch+1 from RUN
    always_comb begin
        if ((state_q == ST_RUN) && (ch_q != LAST_CH)) begin
            rd_ch_s = ch_q + CH_W'(1);
        end else begin
            rd_ch_s = {CH_W{1'b0}};
        end
    end

    assign rd_delay_s = delay_q[rd_ch_s];

`ifdef DELAY_SEQ_SA_ZERO_PAD_EN
    logic [DELAY_WIDTH:0] rd_sum_s;
    logic                 pad_q;

    assign rd_sum_s  = {1'b0, point_q} + {1'b0, rd_delay_s};
    assign rd_addr_s = rd_sum_s[DELAY_WIDTH-1:0];

    // Remember whether the fetched address ran past the end of the buffer
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pad_q <= 1'b0;
        end else begin
            pad_q <= rd_sum_s[DELAY_WIDTH];
        end
    end

    assign sample_ok_s = ~pad_q;
`else
    assign rd_addr_s   = point_q + rd_delay_s;
    assign sample_ok_s = 1'b1;
`endif

    // Sample buffers: store at wr_ptr, registered read-first fetch (contents survive reset)
    always_ff @(posedge clk_i) begin
        if (in_valid_i) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                mem_q[c][wr_ptr_q] <= in_samples_i[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        rd_data_q <= mem_q[rd_ch_s][rd_addr_s];
    end

    // Moore outputs decoded straight from the state register
    always_comb begin
        req_ready_o    = (state_q == ST_IDLE);
        start_sum_o    = (state_q == ST_START);
        sum_en_o       = (state_q == ST_RUN);
        done_channel_o = (state_q == ST_DONE);
        if ((state_q == ST_RUN) && sample_ok_s) begin
            delayed_sample_o = rd_data_q;
        end else begin
            delayed_sample_o = {DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_delay_seq_sa.sv
// Scoreboard bench for delay_seq_sa: stimulus tasks push expected samples and
// frame sums into queues; a negedge monitor pops and compares whenever the DUT
// frames output. Buffer preload: address a, channel c holds c*256 + a.
module tb_delay_seq_sa;

    localparam int DW = 16;
    localparam int N  = 4;
    localparam int D  = 64;
    localparam int AW = 6;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [DW*N-1:0] in_samples;
    logic            delay_we;
    logic [1:0]      delay_ch;
    logic [AW-1:0]   delay_val;
    logic            req_valid;
    logic [AW-1:0]   req_point;
    logic            req_ready;
    logic            start_sum;
    logic            sum_en;
    logic [DW-1:0]   delayed_sample;
    logic            done_channel;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    int phase  = 0;
    int acc    = 0;
    logic [DW-1:0] exp_q[$];
    int            exp_sum_q[$];

    delay_seq_sa #(.DATA_WIDTH(DW), .NUM_CHANNELS(N), .DEPTH(D), .DELAY_WIDTH(AW)) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .in_valid_i      (in_valid),
        .in_samples_i    (in_samples),
        .delay_we_i      (delay_we),
        .delay_ch_i      (delay_ch),
        .delay_val_i     (delay_val),
        .req_valid_i     (req_valid),
        .req_point_i     (req_point),
        .req_ready_o     (req_ready),
        .start_sum_o     (start_sum),
        .sum_en_o        (sum_en),
        .delayed_sample_o(delayed_sample),
        .done_channel_o  (done_channel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: framing rules and scoreboard comparison of streamed samples
    always @(negedge clk) begin
        if (mon_en) begin
            check("no_overlap", {31'd0, start_sum & sum_en}, 32'd0);
            if (!sum_en) check("zero_when_idle", {16'd0, delayed_sample}, 32'd0);
            if (start_sum) begin
                check("start_phase", phase, 32'd0);
                phase = 1;
                acc   = 0;
            end
            if (sum_en) begin
                check("sum_en_phase", {31'd0, (phase >= 1 && phase <= N)}, 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sample: got %0d expected none", delayed_sample);
                end else begin
                    check("sample", {16'd0, delayed_sample}, {16'd0, exp_q.pop_front()});
                end
                acc   = acc + int'(delayed_sample);
                phase = phase + 1;
            end
            if (done_channel) begin
                check("done_phase", phase, N + 1);
                if (exp_sum_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_sum: got %0d expected none", acc);
                end else begin
                    check("frame_sum", acc, exp_sum_q.pop_front());
                end
                phase = 0;
            end
            if (reset) begin
                phase = 0;
                exp_q.delete();
                exp_sum_q.delete();
            end
        end
    end

    task automatic preload();
        for (int a = 0; a < D; a++) begin
            in_valid = 1'b1;
            for (int c = 0; c < N; c++) in_samples[c*DW +: DW] = 16'(c * 256 + a);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic set_delay(input logic [1:0] ch, input logic [AW-1:0] val);
        delay_we  = 1'b1;
        delay_ch  = ch;
        delay_val = val;
        tick();
        delay_we  = 1'b0;
    endtask

    task automatic push4(input logic [DW-1:0] e0, e1, e2, e3);
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        exp_q.push_back(e3);
        exp_sum_q.push_back(int'(e0) + int'(e1) + int'(e2) + int'(e3));
    endtask

    // One request from IDLE with cycle-exact framing checks T+1 .. T+7
    task automatic frame(input logic [AW-1:0] pt, input logic [DW-1:0] e0, e1, e2, e3,
                         input bit poke_wr, input bit poke_dly);
        push4(e0, e1, e2, e3);
        req_valid = 1'b1;
        req_point = pt;
        check("ready_before", {31'd0, req_ready}, 32'd1);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) begin
                req_valid = 1'b0;
                if (poke_wr) begin
                    in_valid = 1'b1;
                    for (int c = 0; c < N; c++) in_samples[c*DW +: DW] = 16'(16'hB000 + c);
                end
            end
            if (k == 2) in_valid = 1'b0;
            if (k == 3 && poke_dly) begin
                delay_we  = 1'b1;
                delay_ch  = 2'd2;
                delay_val = 6'd5;
            end
            if (k == 4) delay_we = 1'b0;
            check("ready_t", {31'd0, req_ready}, {31'd0, (k == 7)});
            check("start_t", {31'd0, start_sum}, {31'd0, (k == 1)});
            check("sum_en_t", {31'd0, sum_en}, {31'd0, (k >= 2 && k <= 5)});
            check("done_t", {31'd0, done_channel}, {31'd0, (k == 6)});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cyc[$];
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_samples = '0;
        delay_we   = 1'b0;
        delay_ch   = 2'd0;
        delay_val  = 6'd0;
        req_valid  = 1'b0;
        req_point  = 6'd0;
        tick();
        tick();
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_start", {31'd0, start_sum}, 32'd0);
        check("rst_sum_en", {31'd0, sum_en}, 32'd0);
        check("rst_done", {31'd0, done_channel}, 32'd0);
        check("rst_sample", {16'd0, delayed_sample}, 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        preload();
        set_delay(2'd0, 6'd0);
        set_delay(2'd1, 6'd1);
        set_delay(2'd2, 6'd2);
        set_delay(2'd3, 6'd3);

        // Basic frame, sum 1582
        frame(6'd10, 16'd10, 16'd267, 16'd524, 16'd781, 1'b0, 1'b0);
        // End-of-buffer behaviour
`ifdef DELAY_SEQ_SA_ZERO_PAD_EN
        frame(6'd62, 16'd62, 16'd319, 16'd0, 16'd0, 1'b0, 1'b0);
`else
        frame(6'd62, 16'd62, 16'd319, 16'd512, 16'd769, 1'b0, 1'b0);
`endif

        // req_valid held high: accepts at cycle 0 and 7 only
        tick();
        push4(16'd10, 16'd267, 16'd524, 16'd781);
        push4(16'd10, 16'd267, 16'd524, 16'd781);
        req_valid = 1'b1;
        req_point = 6'd10;
        for (int i = 0; i < 14; i++) begin
            if (req_ready) acc_cyc.push_back(i);
            tick();
        end
        req_valid = 1'b0;
        check("held_accepts", acc_cyc.size(), 32'd2);
        if (acc_cyc.size() == 2) begin
            check("held_first", acc_cyc[0], 32'd0);
            check("held_gap", acc_cyc[1] - acc_cyc[0], 32'd7);
        end

        // Delay write during RUN is dropped
        frame(6'd10, 16'd10, 16'd267, 16'd524, 16'd781, 1'b0, 1'b1);
        frame(6'd10, 16'd10, 16'd267, 16'd524, 16'd781, 1'b0, 1'b0);

        // Reset in the second RUN cycle
        tick();
        push4(16'd10, 16'd267, 16'd524, 16'd781);
        req_valid = 1'b1;
        req_point = 6'd10;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst_start", {31'd0, start_sum}, 32'd0);
        check("mid_rst_sum_en", {31'd0, sum_en}, 32'd0);
        check("mid_rst_done", {31'd0, done_channel}, 32'd0);
        check("mid_rst_sample", {16'd0, delayed_sample}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("no_late_frame", {30'd0, done_channel, sum_en}, 32'd0);
        end
        // Delays were cleared by reset
        frame(6'd0, 16'd0, 16'd256, 16'd512, 16'd768, 1'b0, 1'b0);

        // Wrap of wr_ptr and read-first collision
        preload();
        in_valid = 1'b1;
        for (int c = 0; c < N; c++) in_samples[c*DW +: DW] = 16'(16'hA000 + c);
        tick();
        in_valid = 1'b0;
        frame(6'd1, 16'd1, 16'hB001, 16'hB002, 16'hB003, 1'b1, 1'b0);
        frame(6'd0, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 1'b0, 1'b0);

        tick();
        tick();
        check("sb_samples_drained", exp_q.size(), 32'd0);
        check("sb_sums_drained", exp_sum_q.size(), 32'd0);
        check("end_phase", phase, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
